// File: rtl/rv32i_types.sv
// Shared RV32 datapath types, extended for the multi-cycle MUL/DIV unit.
//
// Contents:
//   muldiv_op_t     funct3 encoding of the eight RV32M operations.
//   muldiv_state_t  states of the MUL/DIV unit sequencer.
//   muldiv_req_t    request bundle {op, a, b, tag} at the core's native width.
//   MULDIV_*_FILL   fill bits for the divide-by-zero quotient and the signed
//                   overflow remainder; replicate to any operand width.
package rv32i_types;

  localparam int RV_XLEN  = 32;
  localparam int RV_TAG_W = 5;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } muldiv_state_t;

  typedef struct packed {
    muldiv_op_t            op;
    logic [RV_XLEN-1:0]    a;
    logic [RV_XLEN-1:0]    b;
    logic [RV_TAG_W-1:0]   tag;
  } muldiv_req_t;

  // Divide by zero: quotient is all ones, remainder is the dividend.
  localparam logic MULDIV_DIVZ_Q_FILL = 1'b1;
  // Signed overflow (MIN / -1): quotient is the dividend, remainder is zero.
  localparam logic MULDIV_OVF_R_FILL  = 1'b0;

  // Native-width patterns for consumers that work at RV_XLEN.
  localparam logic [RV_XLEN-1:0] MULDIV_DIVZ_QUOT = {RV_XLEN{MULDIV_DIVZ_Q_FILL}};
  localparam logic [RV_XLEN-1:0] MULDIV_OVF_REM   = {RV_XLEN{MULDIV_OVF_R_FILL}};

endpackage

// File: rtl/muldiv_div_iter.sv
// Iterative restoring divider core for the MUL/DIV unit.
//
// Works on unsigned magnitudes and produces one quotient bit per cycle for
// XLEN cycles after start. Sign flags captured at start are applied to the
// quotient/remainder outputs combinationally, so the caller can sample the
// corrected result the cycle after 'last'.
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   start       load dividend/divisor magnitudes and sign flags, begin
//   abort       stop iterating (counter cleared); has priority over start
//   dividend    |a|
//   divisor     |b| (non-zero; zero is handled by the caller)
//   neg_quot    negate the quotient on output
//   neg_rem     negate the remainder on output
//   last        high during the final iteration cycle
//   quotient    sign-corrected quotient
//   remainder   sign-corrected remainder
module muldiv_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            neg_quot,
  input  logic            neg_rem,
  output logic            last,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CNT_W = $clog2(XLEN + 1);

  logic [XLEN-1:0]  quo_reg, quo_next;
  logic [XLEN-1:0]  rem_reg, rem_next;
  logic [XLEN-1:0]  dvs_reg, dvs_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             neg_q_reg, neg_q_next;
  logic             neg_r_reg, neg_r_next;

  logic [XLEN:0]    shifted;
  logic [XLEN:0]    trial;

  always_comb begin
    quo_next   = quo_reg;
    rem_next   = rem_reg;
    dvs_next   = dvs_reg;
    cnt_next   = cnt_reg;
    neg_q_next = neg_q_reg;
    neg_r_next = neg_r_reg;

    // Partial remainder shifted left with the next dividend bit brought in
    // from the top of the quotient register (dividend shifts out as quotient
    // bits shift in).
    shifted = {rem_reg, quo_reg[XLEN-1]};
    // Since rem < divisor, shifted < 2*divisor: bit XLEN of the trial
    // difference is set exactly when the subtraction would go negative.
    trial   = shifted - {1'b0, dvs_reg};

    if (abort) begin
      cnt_next = '0;
    end else if (start) begin
      quo_next   = dividend;
      rem_next   = '0;
      dvs_next   = divisor;
      cnt_next   = CNT_W'(XLEN);
      neg_q_next = neg_quot;
      neg_r_next = neg_rem;
    end else if (cnt_reg != '0) begin
      if (!trial[XLEN]) begin
        rem_next = trial[XLEN-1:0];
        quo_next = {quo_reg[XLEN-2:0], 1'b1};
      end else begin
        rem_next = shifted[XLEN-1:0];
        quo_next = {quo_reg[XLEN-2:0], 1'b0};
      end
      cnt_next = cnt_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_reg   <= '0;
      rem_reg   <= '0;
      dvs_reg   <= '0;
      cnt_reg   <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
    end else begin
      quo_reg   <= quo_next;
      rem_reg   <= rem_next;
      dvs_reg   <= dvs_next;
      cnt_reg   <= cnt_next;
      neg_q_reg <= neg_q_next;
      neg_r_reg <= neg_r_next;
    end
  end

  assign last      = (cnt_reg == CNT_W'(1));
  assign quotient  = neg_q_reg ? -quo_reg : quo_reg;
  assign remainder = neg_r_reg ? -rem_reg : rem_reg;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle RV32M functional unit for the EX stage.
//
// Accepts one MUL/DIV-class operation over a valid/ready handshake, holds
// busy high while working, and returns result + destination tag over a second
// valid/ready handshake. Multiplies take MUL_CYCLES cycles in MUL; divides run
// an XLEN-cycle restoring divider followed by one sign-fix cycle. Divide by
// zero and signed overflow finish straight from IDLE.
//
// Build option: MULDIV_EARLY_OUT_EN -- when defined, divides with
// |a| < |b| (b != 0) also finish straight from IDLE (quotient 0, remainder a).
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   req_valid    operation offered
//   req_ready    unit can accept (IDLE and no flush)
//   req_op       funct3 operation code
//   req_a/req_b  rs1 / rs2 operand values
//   req_tag      destination register tag
//   flush        kill any in-flight operation
//   resp_valid   result available (DONE)
//   resp_ready   consumer takes the result
//   resp_data    result value
//   resp_tag     tag of the result
//   busy         unit not idle; stalls EX
module ex_muldiv_unit
  import rv32i_types::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 2,
  parameter int TAG_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy
);

  localparam int MCNT_W = $clog2(MUL_CYCLES + 1);

  muldiv_state_t     state_reg, state_next;
  muldiv_op_t        op_reg, op_next;
  logic [XLEN-1:0]   a_reg, a_next;
  logic [XLEN-1:0]   b_reg, b_next;
  logic [TAG_W-1:0]  tag_reg, tag_next;
  logic [XLEN-1:0]   data_reg, data_next;
  logic [MCNT_W-1:0] mcnt_reg, mcnt_next;

  // ---------------------------------------------------------------------
  // Request decode (evaluated on the live request inputs at acceptance)
  // ---------------------------------------------------------------------
  muldiv_op_t      req_op_e;
  logic            div_signed;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_by_zero, div_ovf, early_out, div_short;
  logic [XLEN-1:0] short_result;

  assign req_op_e    = muldiv_op_t'(req_op);
  assign div_signed  = (req_op_e == OP_DIV) || (req_op_e == OP_REM);
  assign a_neg       = div_signed && req_a[XLEN-1];
  assign b_neg       = div_signed && req_b[XLEN-1];
  assign a_mag       = a_neg ? -req_a : req_a;
  assign b_mag       = b_neg ? -req_b : req_b;
  assign div_by_zero = (req_b == '0);
  assign div_ovf     = div_signed && (req_a == {1'b1, {(XLEN-1){1'b0}}}) && (req_b == '1);

`ifdef MULDIV_EARLY_OUT_EN
  assign early_out = !div_by_zero && (a_mag < b_mag);
`else
  assign early_out = 1'b0;
`endif

  assign div_short = div_by_zero || div_ovf || early_out;

  // req_op[1] selects REM/REMU over DIV/DIVU.
  always_comb begin
    short_result = '0;
    if (div_by_zero) begin
      short_result = req_op[1] ? req_a : {XLEN{MULDIV_DIVZ_Q_FILL}};
    end else if (div_ovf) begin
      short_result = req_op[1] ? {XLEN{MULDIV_OVF_R_FILL}} : req_a;
    end else begin
      short_result = req_op[1] ? req_a : '0;
    end
  end

  // ---------------------------------------------------------------------
  // Multiplier: operands extended to 2*XLEN per op signedness; the product
  // settles while the MUL down-counter runs.
  // ---------------------------------------------------------------------
  logic              mul_a_signed, mul_b_signed;
  logic [2*XLEN-1:0] mul_ext_a, mul_ext_b, product;
  logic [XLEN-1:0]   mul_result;

  assign mul_a_signed = (op_reg == OP_MUL) || (op_reg == OP_MULH) || (op_reg == OP_MULHSU);
  assign mul_b_signed = (op_reg == OP_MUL) || (op_reg == OP_MULH);
  assign mul_ext_a    = {{XLEN{mul_a_signed && a_reg[XLEN-1]}}, a_reg};
  assign mul_ext_b    = {{XLEN{mul_b_signed && b_reg[XLEN-1]}}, b_reg};
  assign product      = mul_ext_a * mul_ext_b;
  assign mul_result   = (op_reg == OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

  // ---------------------------------------------------------------------
  // Divider
  // ---------------------------------------------------------------------
  logic            div_start, div_last;
  logic [XLEN-1:0] div_quot, div_rem;

  muldiv_div_iter #(
    .XLEN(XLEN)
  ) u_div_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .abort     (flush),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .neg_quot  (a_neg ^ b_neg),
    .neg_rem   (a_neg),
    .last      (div_last),
    .quotient  (div_quot),
    .remainder (div_rem)
  );

  // ---------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------
  assign busy       = (state_reg != ST_IDLE);
  assign req_ready  = (state_reg == ST_IDLE) && !flush;
  assign resp_valid = (state_reg == ST_DONE);
  assign resp_data  = data_reg;
  assign resp_tag   = tag_reg;

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    tag_next   = tag_reg;
    data_next  = data_reg;
    mcnt_next  = mcnt_reg;
    div_start  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          op_next  = req_op_e;
          a_next   = req_a;
          b_next   = req_b;
          tag_next = req_tag;
          if (!req_op[2]) begin
            state_next = ST_MUL;
            mcnt_next  = MCNT_W'(MUL_CYCLES);
          end else if (div_short) begin
            state_next = ST_DONE;
            data_next  = short_result;
          end else begin
            state_next = ST_DIV;
            div_start  = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (mcnt_reg == MCNT_W'(1)) begin
          state_next = ST_DONE;
          data_next  = mul_result;
          mcnt_next  = '0;
        end else begin
          mcnt_next = mcnt_reg - MCNT_W'(1);
        end
      end
      ST_DIV: begin
        if (div_last) begin
          state_next = ST_FIX;
        end
      end
      ST_FIX: begin
        // Divider outputs are already sign-corrected; capture the one asked for.
        state_next = ST_DONE;
        data_next  = op_reg[1] ? div_rem : div_quot;
      end
      ST_DONE: begin
        if (resp_valid && resp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Flush drops whatever is in flight; a DONE handshake in the same cycle
    // still completes since both lead to IDLE.
    if (flush && (state_reg != ST_IDLE)) begin
      state_next = ST_IDLE;
      mcnt_next  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      op_reg    <= OP_MUL;
      a_reg     <= '0;
      b_reg     <= '0;
      tag_reg   <= '0;
      data_reg  <= '0;
      mcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      tag_reg   <= tag_next;
      data_reg  <= data_next;
      mcnt_reg  <= mcnt_next;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit (XLEN=32, MUL_CYCLES=2).
// Results and latencies come from an arithmetic reference model of RV32M.
module tb_ex_muldiv_unit;

  localparam int XLEN       = 32;
  localparam int MUL_CYCLES = 2;
  localparam int TAG_W      = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [2:0]       req_op = 3'd0;
  logic [XLEN-1:0]  req_a = '0;
  logic [XLEN-1:0]  req_b = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             flush = 1'b0;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [XLEN-1:0]  resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;

  ex_muldiv_unit #(
    .XLEN(XLEN), .MUL_CYCLES(MUL_CYCLES), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_tag(resp_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    bit ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 64'd0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    bit sgn;
    sgn = (op == 3'd4) || (op == 3'd6);
    if (!op[2]) return MUL_CYCLES + 1;
    if (b == 0) return 1;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_EARLY_OUT_EN
    begin
      longint ma, mb;
      ma = sgn ? longint'({{32{a[31]}}, a}) : longint'({32'd0, a});
      mb = sgn ? longint'({{32{b[31]}}, b}) : longint'({32'd0, b});
      if (ma < 0) ma = -ma;
      if (mb < 0) mb = -mb;
      if (ma < mb) return 1;
    end
`endif
    return XLEN + 2;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // One full transaction. aligned=1: caller is already just after a rising
  // edge and this cycle becomes the accept cycle (cycle 0).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input int hold, input bit aligned);
    logic [31:0] exp;
    int exp_lat;
    int lat;
    bit busy_ok;
    exp     = ref_result(op, a, b);
    exp_lat = ref_latency(op, a, b);
    if (!aligned) begin
      @(posedge clk); #1;
    end
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    @(posedge clk); #1;
    // Scramble the request inputs: the unit must have latched them.
    req_valid = 1'b0; req_op = 3'($urandom); req_a = 32'($urandom);
    req_b = 32'($urandom); req_tag = 5'($urandom);
    lat = 1;
    busy_ok = 1'b1;
    @(negedge clk);
    while (!resp_valid && lat < 200) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
      @(negedge clk);
    end
    check("latency", lat, exp_lat);
    check("busy_during_op", busy_ok, 1);
    check("resp_data", resp_data, exp);
    check("resp_tag", resp_tag, tag);
    check("busy_done", busy, 1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("hold_valid", resp_valid, 1);
      check("hold_data", resp_data, exp);
      check("hold_tag", resp_tag, tag);
      check("hold_req_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    check("post_valid", resp_valid, 0);
    check("post_req_ready", req_ready, 1);
    $display("txn op=%0d a=%08h b=%08h tag=%0d data=%08h exp=%08h lat=%0d exp_lat=%0d",
             op, a, b, tag, resp_data, exp, lat, exp_lat);
  endtask

  // DIV interrupted in cycle 10 by flush (use_rst=0) or reset (use_rst=1).
  task automatic kill_div(input bit use_rst);
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 3'd4; req_a = 32'h7000_0000 | 32'($urandom_range(0, 255));
    req_b = 32'd3; req_tag = 5'd9;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    @(negedge clk);
    check("kill_busy_c10", busy, 1);
    check("kill_valid_c10", resp_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0;
    check("kill_busy_c11", busy, 0);
    check("kill_valid_c11", resp_valid, 0);
    if (use_rst) begin
      check("rst_data", resp_data, 0);
      check("rst_tag", resp_tag, 0);
      $display("txn reset mid-DIV: busy=%0d valid=%0d data=%08h tag=%0d",
               busy, resp_valid, resp_data, resp_tag);
    end else begin
      $display("txn flush mid-DIV: busy=%0d valid=%0d", busy, resp_valid);
      run_op(3'd0, 32'd1234, 32'd5678, 5'd17, 0, 1'b1);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", resp_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_data", resp_data, 0);
    check("reset_tag", resp_tag, 0);
    check("reset_req_ready", req_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed operations
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd3, 0, 1'b0);
    run_op(3'd3, 32'h8000_0000, 32'h8000_0000, 5'd4, 0, 1'b0);
    run_op(3'd0, 32'h8000_0000, 32'h8000_0000, 5'd5, 0, 1'b0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, 0, 1'b0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, 0, 1'b0);
    run_op(3'd5, 32'd5, 32'd0, 5'd8, 0, 1'b0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0, 1'b0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0, 1'b0);
    run_op(3'd5, 32'd3, 32'd10, 5'd12, 0, 1'b0);
    run_op(3'd7, 32'd3, 32'd10, 5'd13, 0, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, 5, 1'b0);

    // Flush coincident with a request blocks acceptance
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 3'd0; req_a = 32'd7; req_b = 32'd9; flush = 1'b1;
    @(negedge clk);
    check("flush_blocks_ready", req_ready, 0);
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    check("flush_blocks_busy", busy, 0);

    kill_div(1'b0);
    kill_div(1'b1);
    run_op(3'd7, 32'd100, 32'd7, 5'd21, 1, 1'b0);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom), pick(), pick(), 5'($urandom), $urandom_range(0, 3), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
